// File: rtl/fft_frame_loader.sv
// Collects 16 streamed complex samples into a parallel frame for fft_16pt,
// pulses start, then holds the frame until the FFT reports done.
module fft_frame_loader #(
    parameter int unsigned WIDTH       = 36,
    parameter int unsigned BIT_REVERSE = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [WIDTH-1:0] f [0:15],
    output logic             start,
    input  logic             fft_done,
    output logic             busy,
    output logic             resync,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic       done_q;
    logic       xfer;
    logic       mid_sof;
    logic       done_edge;
    logic [3:0] wr_idx;

    function automatic logic [3:0] map_idx(input logic [3:0] n);
        if (BIT_REVERSE != 0) begin
            return {n[0], n[1], n[2], n[3]};
        end
        return n;
    endfunction

    // Handshake and write-address decode
    always_comb begin
        in_ready  = (state == FILL) && !reset;
        xfer      = in_valid && in_ready;
        mid_sof   = in_sof && (idx != 4'd0);
        wr_idx    = mid_sof ? 4'd0 : map_idx(idx);
        done_edge = fft_done && !done_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FILL;
            idx       <= 4'd0;
            done_q    <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
            resync    <= 1'b0;
            frame_cnt <= '0;
            for (int i = 0; i < 16; i++) begin
                f[i] <= '0;
            end
        end else begin
            done_q <= fft_done;
            start  <= 1'b0;
            resync <= 1'b0;
            case (state)
                FILL: begin
                    if (xfer) begin
                        f[wr_idx] <= in_data;
                        if (mid_sof) begin
                            // Restart the frame: this sample becomes entry 0
                            idx    <= 4'd1;
                            resync <= 1'b1;
                        end else if (idx == 4'd15) begin
                            idx   <= 4'd0;
                            state <= START;
                            start <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_edge) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        idx       <= 4'd0;
                        busy      <= 1'b0;
                        state     <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader; a natural-order and a
// bit-reversed instance share all inputs and stay in lockstep.
module tb_fft_frame_loader;

    localparam int unsigned WIDTH = 36;
    localparam int unsigned CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_sof;
    logic             fft_done;

    logic             in_ready0, start0, busy0, resync0;
    logic             in_ready1, start1, busy1, resync1;
    logic [WIDTH-1:0] f0 [0:15];
    logic [WIDTH-1:0] f1 [0:15];
    logic [CNT_W-1:0] frame_cnt0, frame_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    fft_frame_loader #(.WIDTH(WIDTH), .BIT_REVERSE(0), .CNT_W(CNT_W)) dut0 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready0), .f(f0), .start(start0),
        .fft_done(fft_done), .busy(busy0), .resync(resync0), .frame_cnt(frame_cnt0)
    );

    fft_frame_loader #(.WIDTH(WIDTH), .BIT_REVERSE(1), .CNT_W(CNT_W)) dut1 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready1), .f(f1), .start(start1),
        .fft_done(fft_done), .busy(busy1), .resync(resync1), .frame_cnt(frame_cnt1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one sample and hold it until accepted (bounded)
    task automatic send(input logic [WIDTH-1:0] d, input logic sof);
        int k;
        in_data  = d;
        in_valid = 1'b1;
        in_sof   = sof;
        k = 0;
        while (!in_ready0 && k < 200) begin
            tick();
            k++;
        end
        if (!in_ready0) check("ready_timeout", 64'(in_ready0), 64'd1);
        tick();
        in_sof = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic done_pulse();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        tick();
    endtask

    function automatic logic [WIDTH-1:0] pat1(input int n);
        return ((n % 4) < 2) ? {18'd1000, 18'd0} : '0;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        fft_done = 1'b0;
        tick();
        tick();
        check("rst_ready", 64'(in_ready0), 64'd0);
        check("rst_start", 64'(start0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_cnt", 64'(frame_cnt0), 64'd0);
        check("rst_f5", 64'(f0[5]), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready0), 64'd1);

        // 1: natural-order frame, start one cycle after 16th transfer
        for (int n = 0; n < 16; n++) begin
            send(pat1(n), 1'b0);
            if (n == 14) check("t1_no_early_start", 64'(start0), 64'd0);
        end
        idle();
        check("t1_start", 64'(start0), 64'd1);
        check("t1_busy", 64'(busy0), 64'd1);
        check("t1_ready_low", 64'(in_ready0), 64'd0);
        for (int n = 0; n < 16; n++) check($sformatf("t1_f%0d", n), 64'(f0[n]), 64'(pat1(n)));
        tick();
        check("t1_start_once", 64'(start0), 64'd0);

        // 2: frame held through 50 cycles of no done, then rising edge
        for (int c = 0; c < 50; c++) begin
            for (int n = 0; n < 16; n++) check("t2_hold_f", 64'(f0[n]), 64'(pat1(n)));
            check("t2_ready_low", 64'(in_ready0), 64'd0);
            tick();
        end
        fft_done = 1'b1;
        tick();
        check("t2_ready", 64'(in_ready0), 64'd1);
        check("t2_busy", 64'(busy0), 64'd0);
        check("t2_cnt", 64'(frame_cnt0), 64'd1);
        fft_done = 1'b0;

        // 3: bit-reversed storage of n = 0..15
        for (int n = 0; n < 16; n++) send(WIDTH'(n), 1'b0);
        idle();
        check("t3_start", 64'(start1), 64'd1);
        check("t3_f8", 64'(f1[8]), 64'd1);
        check("t3_f4", 64'(f1[4]), 64'd2);
        check("t3_f12", 64'(f1[12]), 64'd3);
        check("t3_f15", 64'(f1[15]), 64'd15);
        check("t3_f0", 64'(f1[0]), 64'd0);
        check("t3_f2", 64'(f1[2]), 64'd4);
        check("t3_nat_f3", 64'(f0[3]), 64'd3);
        check("t3_nat_f12", 64'(f0[12]), 64'd12);
        tick();
        done_pulse();
        check("t3_cnt", 64'(frame_cnt1), 64'd2);

        // 4: mid-frame start-of-frame resynchronises
        for (int n = 0; n < 5; n++) send(WIDTH'(100 + n), n == 0);
        send(WIDTH'(77), 1'b1);
        check("t4_resync", 64'(resync0), 64'd1);
        check("t4_f0", 64'(f0[0]), 64'd77);
        check("t4_br_f0", 64'(f1[0]), 64'd77);
        for (int k = 0; k < 15; k++) begin
            send(WIDTH'(200 + k), 1'b0);
            if (k == 0) check("t4_resync_once", 64'(resync0), 64'd0);
            if (k == 13) check("t4_no_early_start", 64'(start0), 64'd0);
        end
        idle();
        check("t4_start", 64'(start0), 64'd1);
        check("t4_f1", 64'(f0[1]), 64'd200);
        check("t4_f15", 64'(f0[15]), 64'd214);
        check("t4_br_f8", 64'(f1[8]), 64'd200);
        tick();
        done_pulse();
        check("t4_cnt", 64'(frame_cnt0), 64'd3);

        // 5: done already high when WAIT is entered is not an event
        for (int n = 0; n < 16; n++) begin
            if (n == 15) fft_done = 1'b1;
            send(WIDTH'(n + 300), 1'b0);
        end
        idle();
        check("t5_start", 64'(start0), 64'd1);
        for (int c = 0; c < 5; c++) tick();
        check("t5_no_exit", 64'(in_ready0), 64'd0);
        check("t5_busy", 64'(busy0), 64'd1);
        fft_done = 1'b0;
        tick();
        check("t5_still_wait", 64'(in_ready0), 64'd0);
        fft_done = 1'b1;
        tick();
        check("t5_exit", 64'(in_ready0), 64'd1);
        check("t5_cnt", 64'(frame_cnt0), 64'd4);
        fft_done = 1'b0;
        tick();

        // 6a: reset while waiting for the FFT
        for (int n = 0; n < 16; n++) send(WIDTH'(n + 400), 1'b0);
        idle();
        tick();
        check("t6_in_wait", 64'(busy0), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_ready_in_rst", 64'(in_ready0), 64'd0);
        tick();
        check("t6_cnt", 64'(frame_cnt0), 64'd0);
        check("t6_busy", 64'(busy0), 64'd0);
        for (int n = 0; n < 16; n++) check("t6_f_zero", 64'(f0[n]), 64'd0);
        reset = 1'b0;
        #1;
        check("t6_ready", 64'(in_ready0), 64'd1);
        done_pulse();
        check("t6_done_ignored", 64'(frame_cnt0), 64'd0);
        check("t6_ready_after_done", 64'(in_ready0), 64'd1);

        // 6b: reset at idx = 7, then a full frame must need 16 transfers
        for (int n = 0; n < 7; n++) send(WIDTH'(n + 500), 1'b0);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 16; n++) check("t6b_f_zero", 64'(f0[n]), 64'd0);
        check("t6b_cnt", 64'(frame_cnt0), 64'd0);
        done_pulse();
        check("t6b_done_ignored", 64'(frame_cnt0), 64'd0);
        for (int n = 0; n < 16; n++) begin
            send(WIDTH'(n + 600), 1'b0);
            if (n == 14) check("t6b_no_early_start", 64'(start0), 64'd0);
        end
        idle();
        check("t6b_start", 64'(start0), 64'd1);
        check("t6b_f0", 64'(f0[0]), 64'd600);
        check("t6b_f15", 64'(f0[15]), 64'd615);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
